// File: rtl/instr_decoder_pipe.sv
// -----------------------------------------------------------------------------
// instr_decoder_pipe
//
// Pipelined instruction decoder for the 8-bit core ISA. An instruction
// accepted from program memory on edge N sits in the instruction register
// and is decoded during cycle N+1. Decode outputs drive the datapath source
// mux and the register write enables.
//
// Features:
//   - valid/ready handshake with the fetch stage, plus an external stall.
//   - Multi-cycle data-memory reads. A MOVE sourcing dm holds the decoder
//     for DM_LAT cycles and writes only in the last of them.
//   - Branch-shadow squashing. After a taken JUMP/JNZ, the next BR_SHADOW
//     accepted instructions load as dead (ir_valid=0).
//
// Optional feature macro: ID_PERF_CNT_EN
//   When defined, adds the retired_cnt, stall_cnt and squash_cnt outputs.
//
// Ports:
//   clk                        clock, all state on rising edge
//   sync_reset                 synchronous active-high reset
//   next_instr[7:0], in_valid  instruction offered by fetch
//   in_ready                   decoder takes next_instr on this edge
//   stall                      freeze decoder state, decode not live
//   alu_zero                   zero flag, resolves JNZ
//   ir[7:0], ir_valid          instruction register and its liveness
//   jmp, jmp_nz                live jump / conditional jump
//   ir_nibble[3:0]             ir[3:0] (immediate / jump target)
//   i_sel, x_sel, y_sel        datapath selects
//   source_sel[3:0]            source mux select
//   reg_en[NREG-1:0]           register write enables (bit 8 = o)
//   nop_c8/cf/d8/df            registered NOP-pattern detect for ir
//   retired_cnt, stall_cnt,    performance counters (ID_PERF_CNT_EN only)
//   squash_cnt
// -----------------------------------------------------------------------------
module instr_decoder_pipe #(
   parameter int DM_LAT    = 1,
   parameter int BR_SHADOW = 1,
   parameter int NREG      = 9
) (
   input  logic            clk,
   input  logic            sync_reset,
   input  logic [7:0]      next_instr,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            stall,
   input  logic            alu_zero,
   output logic [7:0]      ir,
   output logic            ir_valid,
   output logic            jmp,
   output logic            jmp_nz,
   output logic [3:0]      ir_nibble,
   output logic            i_sel,
   output logic            x_sel,
   output logic            y_sel,
   output logic [3:0]      source_sel,
   output logic [NREG-1:0] reg_en,
`ifdef ID_PERF_CNT_EN
   output logic [15:0]     retired_cnt,
   output logic [15:0]     stall_cnt,
   output logic [7:0]      squash_cnt,
`endif
   output logic            nop_c8,
   output logic            nop_cf,
   output logic            nop_d8,
   output logic            nop_df
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DM_WAIT = 2'd1,
      ST_SQUASH  = 2'd2
   } state_t;

   localparam logic [1:0] DM_LAST  = 2'(DM_LAT - 1);
   localparam logic [1:0] SHADOW_N = 2'(BR_SHADOW);
   localparam logic       DM_MULTI = (DM_LAT > 1);
   localparam logic       SHADOW_ON = (BR_SHADOW > 0);

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] sq_q, sq_d;
   logic [7:0] ir_q, ir_d;
   logic       ir_valid_q, ir_valid_d;
   logic [3:0] nop_q, nop_d;

   logic       is_load_s, is_move_s, is_alu_s, is_jump_s, is_jnz_s;
   logic [2:0] ld_dst_s, mv_dst_s, mv_src_s;
   logic       dm_read_s, hold_dm_s, live_s, taken_s, squash_now_s, accept_s;
   logic [1:0] slots_s;

   logic [NREG-1:0] reg_en_s;
   logic [3:0]      source_sel_s;
   logic            i_sel_s, x_sel_s, y_sel_s, jmp_s, jmp_nz_s, in_ready_s;

   assign is_load_s = (ir_q[7] == 1'b0);
   assign is_move_s = (ir_q[7:6] == 2'b10);
   assign is_alu_s  = (ir_q[7:5] == 3'b110);
   assign is_jump_s = (ir_q[7:4] == 4'b1110);
   assign is_jnz_s  = (ir_q[7:4] == 4'b1111);
   assign ld_dst_s  = ir_q[6:4];
   assign mv_dst_s  = ir_q[5:3];
   assign mv_src_s  = ir_q[2:0];
   assign dm_read_s = is_move_s && (mv_src_s == 3'd7);

   // The dm read holds the decoder from its first decode cycle until the
   // counter reaches the last latency cycle. Only that last cycle writes.
   assign hold_dm_s = ir_valid_q &&
                      ((state_q == ST_RUN && dm_read_s && DM_MULTI) ||
                       (state_q == ST_DM_WAIT && cnt_q != DM_LAST));

   assign in_ready_s   = !sync_reset && !stall && !hold_dm_s;
   assign accept_s     = in_ready_s;
   assign live_s       = !sync_reset && ir_valid_q && !stall && !hold_dm_s;
   assign taken_s      = live_s && SHADOW_ON && (is_jump_s || (is_jnz_s && !alu_zero));
   // The instruction loaded on the edge that resolves the jump is already in the shadow.
   assign squash_now_s = taken_s || (state_q == ST_SQUASH);
   assign slots_s      = taken_s ? SHADOW_N : sq_q;

   // FSM next-state: dm latency counter and remaining squash slots
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sq_d    = sq_q;
      if (stall) begin
         state_d = state_q;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (hold_dm_s) begin
                  state_d = ST_DM_WAIT;
                  cnt_d   = 2'd1;
               end else if (taken_s) begin
                  sq_d    = in_valid ? (slots_s - 2'd1) : slots_s;
                  state_d = (sq_d == 2'd0) ? ST_RUN : ST_SQUASH;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DM_WAIT: begin
               if (cnt_q == DM_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = 2'd0;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
            ST_SQUASH: begin
               // Bubbles do not use up a shadow slot
               if (in_valid) begin
                  sq_d    = sq_q - 2'd1;
                  state_d = (sq_q == 2'd1) ? ST_RUN : ST_SQUASH;
               end else begin
                  sq_d = sq_q;
               end
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = 2'd0;
               sq_d    = 2'd0;
            end
         endcase
      end
   end

   // Next-state for the instruction register, its liveness and NOP flags
   always_comb begin
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      nop_d      = nop_q;
      if (accept_s) begin
         ir_d       = next_instr;
         ir_valid_d = in_valid && !squash_now_s;
         nop_d[0]   = (next_instr == 8'hC8) && in_valid && !squash_now_s;
         nop_d[1]   = (next_instr == 8'hCF) && in_valid && !squash_now_s;
         nop_d[2]   = (next_instr == 8'hD8) && in_valid && !squash_now_s;
         nop_d[3]   = (next_instr == 8'hDF) && in_valid && !squash_now_s;
      end else begin
         ir_d = ir_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q    <= ST_RUN;
         cnt_q      <= 2'd0;
         sq_q       <= 2'd0;
         ir_q       <= 8'hC8;
         ir_valid_q <= 1'b0;
         nop_q      <= 4'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sq_q       <= sq_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         nop_q      <= nop_d;
      end
   end

   // Instruction decode; reset overrides, otherwise dead decode unless live
   always_comb begin
      reg_en_s     = '0;
      source_sel_s = 4'd8;
      i_sel_s      = 1'b1;
      x_sel_s      = ir_q[4];
      y_sel_s      = ir_q[3];
      jmp_s        = 1'b0;
      jmp_nz_s     = 1'b0;
      if (sync_reset) begin
         reg_en_s     = '1;
         source_sel_s = 4'd10;
         i_sel_s      = 1'b0;
         x_sel_s      = 1'b0;
         y_sel_s      = 1'b0;
      end else if (live_s) begin
         if (is_load_s) begin
            i_sel_s = (ld_dst_s != 3'd6);
            if (ld_dst_s == 3'd7) begin
               reg_en_s[7] = 1'b1;
               reg_en_s[6] = 1'b1;
            end else if (ld_dst_s == 3'd4) begin
               reg_en_s[8] = 1'b1;
            end else begin
               reg_en_s[ld_dst_s] = 1'b1;
            end
         end else if (is_move_s) begin
            i_sel_s = (mv_dst_s != 3'd6);
            if (mv_src_s == mv_dst_s) begin
               source_sel_s = (mv_src_s == 3'd4) ? 4'd4 : 4'd9;
            end else begin
               source_sel_s = {1'b0, mv_src_s};
            end
            if (mv_dst_s == 3'd4 && mv_src_s == 3'd6) begin
               reg_en_s[8] = 1'b1;
            end else if (mv_dst_s == 3'd7 || (mv_src_s == 3'd7 && mv_dst_s != 3'd6)) begin
               reg_en_s[mv_dst_s] = 1'b1;
               reg_en_s[6]        = 1'b1;
            end else if (mv_dst_s == 3'd4) begin
               reg_en_s[8] = 1'b1;
            end else begin
               reg_en_s[mv_dst_s] = 1'b1;
            end
         end else if (is_alu_s) begin
            reg_en_s[4] = 1'b1;
            reg_en_s[0] = (ir_q == 8'hC0);
         end else begin
            jmp_s    = is_jump_s;
            jmp_nz_s = is_jnz_s;
         end
      end else begin
         reg_en_s = '0;
      end
   end

   assign in_ready   = in_ready_s;
   assign ir         = ir_q;
   assign ir_valid   = ir_valid_q;
   assign ir_nibble  = ir_q[3:0];
   assign jmp        = jmp_s;
   assign jmp_nz     = jmp_nz_s;
   assign i_sel      = i_sel_s;
   assign x_sel      = x_sel_s;
   assign y_sel      = y_sel_s;
   assign source_sel = source_sel_s;
   assign reg_en     = reg_en_s;
   assign nop_c8     = nop_q[0];
   assign nop_cf     = nop_q[1];
   assign nop_d8     = nop_q[2];
   assign nop_df     = nop_q[3];

`ifdef ID_PERF_CNT_EN
   logic [15:0] retired_q, stall_q;
   logic [7:0]  squash_q;

   // Performance counters; all wrap naturally on overflow
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         retired_q <= 16'd0;
         stall_q   <= 16'd0;
         squash_q  <= 8'd0;
      end else begin
         retired_q <= retired_q + {15'd0, live_s};
         stall_q   <= stall_q + {15'd0, !in_ready_s};
         squash_q  <= squash_q + {7'd0, (accept_s && in_valid && squash_now_s)};
      end
   end

   assign retired_cnt = retired_q;
   assign stall_cnt   = stall_q;
   assign squash_cnt  = squash_q;
`endif

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// -----------------------------------------------------------------------------
// Self-checking bench for instr_decoder_pipe (DM_LAT=3, BR_SHADOW=2).
// A behavioural model tracks the instruction register, its age in cycles
// and the number of pending shadow slots. It predicts every output each
// cycle. Directed steps follow the feature list, then a randomized run.
// -----------------------------------------------------------------------------
module tb_instr_decoder_pipe;

   localparam int DM_LAT    = 3;
   localparam int BR_SHADOW = 2;

   logic       clk;
   logic       sync_reset;
   logic [7:0] next_instr;
   logic       in_valid, in_ready, stall, alu_zero;
   logic [7:0] ir;
   logic       ir_valid, jmp, jmp_nz, i_sel, x_sel, y_sel;
   logic [3:0] ir_nibble, source_sel;
   logic [8:0] reg_en;
   logic       nop_c8, nop_cf, nop_d8, nop_df;
`ifdef ID_PERF_CNT_EN
   logic [15:0] retired_cnt, stall_cnt;
   logic [7:0]  squash_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // model state
   logic [7:0] m_ir;
   logic       m_valid;
   int         m_age;
   int         m_shadow;
   logic [3:0] m_nop;
   int         m_ret, m_stc, m_sqc;

   // values observed at the last sample point
   logic [8:0] obs_reg_en;
   logic [3:0] obs_src, obs_nib;
   logic       obs_ready, obs_irv;
   logic [7:0] obs_ir;

   instr_decoder_pipe #(.DM_LAT(DM_LAT), .BR_SHADOW(BR_SHADOW), .NREG(9)) dut (
      .clk(clk), .sync_reset(sync_reset), .next_instr(next_instr),
      .in_valid(in_valid), .in_ready(in_ready), .stall(stall), .alu_zero(alu_zero),
      .ir(ir), .ir_valid(ir_valid), .jmp(jmp), .jmp_nz(jmp_nz), .ir_nibble(ir_nibble),
      .i_sel(i_sel), .x_sel(x_sel), .y_sel(y_sel), .source_sel(source_sel),
      .reg_en(reg_en),
`ifdef ID_PERF_CNT_EN
      .retired_cnt(retired_cnt), .stall_cnt(stall_cnt), .squash_cnt(squash_cnt),
`endif
      .nop_c8(nop_c8), .nop_cf(nop_cf), .nop_d8(nop_d8), .nop_df(nop_df)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ISA rules: returns {i_sel, source_sel, reg_en} for a live instruction
   function automatic logic [13:0] dec(input logic [7:0] x);
      logic [8:0] re;
      logic [3:0] ss;
      logic       is;
      logic [2:0] d, s;
      re = 9'd0; ss = 4'd8; is = 1'b1;
      d = 3'd0; s = 3'd0;
      if (x[7] == 1'b0) begin
         d  = x[6:4];
         is = (d != 3'd6);
         if (d == 3'd7)      re = 9'h0C0;
         else if (d == 3'd4) re = 9'h100;
         else                re = 9'd1 << d;
      end else if (x[7:6] == 2'b10) begin
         d  = x[5:3];
         s  = x[2:0];
         is = (d != 3'd6);
         if (s == d) ss = (s == 3'd4) ? 4'd4 : 4'd9;
         else        ss = {1'b0, s};
         if (d == 3'd4 && s == 3'd6)                   re = 9'h100;
         else if (d == 3'd7 || (s == 3'd7 && d != 3'd6)) re = (9'd1 << d) | 9'h040;
         else if (d == 3'd4)                            re = 9'h100;
         else                                           re = 9'd1 << d;
      end else if (x[7:5] == 3'b110) begin
         re = (x == 8'hC0) ? 9'h011 : 9'h010;
      end
      return {is, ss, re};
   endfunction

   task automatic model_reset();
      m_ir = 8'hC8; m_valid = 1'b0; m_age = 0; m_shadow = 0; m_nop = 4'd0;
      m_ret = 0; m_stc = 0; m_sqc = 0;
   endtask

   // One clock cycle: drive, sample at negedge, compare, advance model.
   task automatic step(input logic r, input logic [7:0] ni, input logic v,
                       input logic st, input logic az);
      logic [13:0] d;
      logic is_dm, fin, live, eready, taken, squashing;
      logic [8:0] e_re;
      logic [3:0] e_ss;
      logic e_is, e_x, e_y, e_j, e_jn;
      int left;
      sync_reset = r; next_instr = ni; in_valid = v; stall = st; alu_zero = az;
      @(negedge clk);
      is_dm  = m_valid && (m_ir[7:6] == 2'b10) && (m_ir[2:0] == 3'd7);
      fin    = !is_dm || (m_age == DM_LAT - 1);
      live   = !r && m_valid && !st && fin;
      eready = !r && !st && fin;
      taken  = live && (BR_SHADOW > 0) &&
               ((m_ir[7:4] == 4'hE) || (m_ir[7:4] == 4'hF && !az));
      d = dec(m_ir);
      if (r) begin
         e_re = 9'h1FF; e_ss = 4'd10; e_is = 1'b0; e_x = 1'b0; e_y = 1'b0; e_j = 1'b0; e_jn = 1'b0;
      end else if (live) begin
         e_re = d[8:0]; e_ss = d[12:9]; e_is = d[13]; e_x = m_ir[4]; e_y = m_ir[3];
         e_j = (m_ir[7:4] == 4'hE); e_jn = (m_ir[7:4] == 4'hF);
      end else begin
         e_re = 9'h000; e_ss = 4'd8; e_is = 1'b1; e_x = m_ir[4]; e_y = m_ir[3]; e_j = 1'b0; e_jn = 1'b0;
      end
      chk("in_ready", 16'(in_ready), 16'(eready));
      chk("ir", 16'(ir), 16'(m_ir));
      chk("ir_valid", 16'(ir_valid), 16'(m_valid));
      chk("ir_nibble", 16'(ir_nibble), 16'(m_ir[3:0]));
      chk("reg_en", 16'(reg_en), 16'(e_re));
      chk("source_sel", 16'(source_sel), 16'(e_ss));
      chk("sels", 16'({i_sel, x_sel, y_sel}), 16'({e_is, e_x, e_y}));
      chk("jumps", 16'({jmp, jmp_nz}), 16'({e_j, e_jn}));
      chk("nops", 16'({nop_df, nop_d8, nop_cf, nop_c8}), 16'(m_nop));
`ifdef ID_PERF_CNT_EN
      chk("retired_cnt", retired_cnt, 16'(m_ret));
      chk("stall_cnt", stall_cnt, 16'(m_stc));
      chk("squash_cnt", 16'(squash_cnt), 16'(m_sqc));
`endif
      obs_reg_en = reg_en; obs_src = source_sel; obs_nib = ir_nibble;
      obs_ready = in_ready; obs_irv = ir_valid; obs_ir = ir;
      if (r) begin
         model_reset();
      end else begin
         m_ret = (m_ret + (live ? 1 : 0)) % 65536;
         m_stc = (m_stc + (eready ? 0 : 1)) % 65536;
         if (st) begin
            m_age = m_age;
         end else if (eready) begin
            squashing = taken || (m_shadow > 0);
            left = taken ? BR_SHADOW : m_shadow;
            if (v && squashing) begin
               left--;
               m_sqc = (m_sqc + 1) % 256;
            end
            m_shadow = left;
            m_ir = ni;
            m_valid = v && !squashing;
            m_nop[0] = (ni == 8'hC8) && v && !squashing;
            m_nop[1] = (ni == 8'hCF) && v && !squashing;
            m_nop[2] = (ni == 8'hD8) && v && !squashing;
            m_nop[3] = (ni == 8'hDF) && v && !squashing;
            m_age = 0;
         end else begin
            m_age++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pick_special(input int k);
      case (k)
         0: return 8'hC8;
         1: return 8'hCF;
         2: return 8'hD8;
         3: return 8'hDF;
         4: return 8'h8F;
         5: return 8'hF5;
         6: return 8'hE3;
         default: return 8'hC0;
      endcase
   endfunction

   initial begin
      logic [7:0] ni;
      sync_reset = 1'b1; next_instr = 8'h00; in_valid = 1'b0; stall = 1'b0; alu_zero = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      // reset held two cycles
      step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("rst_reg_en", 16'(obs_reg_en), 16'h01FF);
      chk("rst_src", 16'(obs_src), 16'd10);
      chk("rst_ready", 16'(obs_ready), 16'd0);
      // first cycle after release, feed LOAD y1<-5
      step(1'b0, 8'h35, 1'b1, 1'b0, 1'b0);
      chk("post_rst_ir", 16'(obs_ir), 16'h00C8);
      chk("post_rst_irv", 16'(obs_irv), 16'd0);
      chk("post_rst_reg_en", 16'(obs_reg_en), 16'd0);

      // load and copy
      step(1'b0, 8'h89, 1'b1, 1'b0, 1'b0);
      chk("load_reg_en", 16'(obs_reg_en), 16'h0008);
      chk("load_nibble", 16'(obs_nib), 16'd5);
      step(1'b0, 8'h8F, 1'b1, 1'b0, 1'b0);
      chk("copy_src", 16'(obs_src), 16'd9);
      chk("copy_reg_en", 16'(obs_reg_en), 16'h0002);

      // dm read with latency 3
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("dm1_ready", 16'(obs_ready), 16'd0);
      chk("dm1_reg_en", 16'(obs_reg_en), 16'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("dm2_ready", 16'(obs_ready), 16'd0);
      chk("dm2_reg_en", 16'(obs_reg_en), 16'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("dm3_reg_en", 16'(obs_reg_en), 16'h0042);
      chk("dm3_src", 16'(obs_src), 16'd7);
      chk("dm3_ready", 16'(obs_ready), 16'd1);
      step(1'b0, 8'hF3, 1'b1, 1'b0, 1'b0);
      chk("after_dm_ir", 16'(obs_ir), 16'h0000);
      chk("after_dm_reg_en", 16'(obs_reg_en), 16'h0001);

      // branch shadow, taken JNZ
      step(1'b0, 8'h10, 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'h20, 1'b1, 1'b0, 1'b0);
      chk("sh_10_irv", 16'(obs_irv), 16'd0);
      chk("sh_10_reg_en", 16'(obs_reg_en), 16'd0);
      step(1'b0, 8'h30, 1'b1, 1'b0, 1'b0);
      chk("sh_20_irv", 16'(obs_irv), 16'd0);
      chk("sh_20_reg_en", 16'(obs_reg_en), 16'd0);
      step(1'b0, 8'hF3, 1'b1, 1'b0, 1'b0);
      chk("sh_30_irv", 16'(obs_irv), 16'd1);
      chk("sh_30_reg_en", 16'(obs_reg_en), 16'h0008);

      // not-taken JNZ
      step(1'b0, 8'h10, 1'b1, 1'b0, 1'b1);
      step(1'b0, 8'hC0, 1'b1, 1'b0, 1'b0);
      chk("nt_10_irv", 16'(obs_irv), 16'd1);
      chk("nt_10_reg_en", 16'(obs_reg_en), 16'h0002);

      // stall while ir=C0
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 8'h40, 1'b1, 1'b1, 1'b0);
         chk("stall_reg_en", 16'(obs_reg_en), 16'd0);
         chk("stall_ir", 16'(obs_ir), 16'h00C0);
      end
      step(1'b0, 8'h40, 1'b1, 1'b0, 1'b0);
      chk("unstall_reg_en", 16'(obs_reg_en), 16'h0011);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("unstall_next_ir", 16'(obs_ir), 16'h0040);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) ni = pick_special(int'($urandom_range(0, 7)));
         else                           ni = 8'($urandom);
         step(($urandom_range(0, 59) == 0), ni, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 6) == 0), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
